// File: rtl/s3g_rx_if.sv
// Received byte stream from the UART receiver into the S3G receive framer.
interface s3g_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/s3g_rx.sv
// S3G receive framer: hunts 0xD5, captures length, up to 16 payload bytes and CRC8.
// Optional inter-byte timeout is built when S3G_RX_TIMEOUT_EN is defined.
module s3g_rx #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  s3g_rx_if.slave    rx,
  output logic       packet_rdy,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       busy,
  output logic [7:0] payload_len,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [7:0] buf4,
  output logic [7:0] buf5,
  output logic [7:0] buf6,
  output logic [7:0] buf7,
  output logic [7:0] buf8,
  output logic [7:0] buf9,
  output logic [7:0] buf10,
  output logic [7:0] buf11,
  output logic [7:0] buf12,
  output logic [7:0] buf13,
  output logic [7:0] buf14,
  output logic [7:0] buf15
);

  localparam logic [7:0] SOF = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CRC} state_t;

  state_t     state, state_nxt;
  logic       busy_nxt, rdy_nxt, crc_err_nxt, len_err_nxt, to_err_nxt;
  logic       ld_len, ld_data, ld_out;
  logic       expire;
  logic [7:0] len_q;
  logic [4:0] byte_cnt;
  logic [7:0] crc;
  logic [7:0] shadow [16];
  logic [7:0] obuf   [16];

  // CRC8, polynomial x^8+x^2+x+1, MSB first (same function as the transmit framer)
  function automatic logic [7:0] next_crc8_d8(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

`ifdef S3G_RX_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] to_cnt;

  // A byte arriving on the expiry cycle wins over the timeout
  assign expire = (state != S_IDLE) && !rx.rx_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (rx.rx_valid || state == S_IDLE || expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0);
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy;
    rdy_nxt     = 1'b0;
    crc_err_nxt = 1'b0;
    len_err_nxt = 1'b0;
    to_err_nxt  = 1'b0;
    ld_len      = 1'b0;
    ld_data     = 1'b0;
    ld_out      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx.rx_valid && rx.rx_data == SOF) begin
          state_nxt = S_LEN;
          busy_nxt  = 1'b1;
        end
      end
      S_LEN: begin
        if (rx.rx_valid) begin
          ld_len = 1'b1;
          if (rx.rx_data == 8'd0) begin
            state_nxt = S_CRC;
          end else if (rx.rx_data <= 8'd16) begin
            state_nxt = S_DATA;
          end else begin
            len_err_nxt = 1'b1;
            busy_nxt    = 1'b0;
            state_nxt   = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (rx.rx_valid) begin
          ld_data = 1'b1;
          if ({3'b000, byte_cnt} + 8'd1 == len_q) state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        if (rx.rx_valid) begin
          if (rx.rx_data == crc) begin
            rdy_nxt = 1'b1;
            ld_out  = 1'b1;
          end else begin
            crc_err_nxt = 1'b1;
          end
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
    if (expire) begin
      state_nxt  = S_IDLE;
      busy_nxt   = 1'b0;
      to_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      packet_rdy  <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= busy_nxt;
      packet_rdy  <= rdy_nxt;
      crc_err     <= crc_err_nxt;
      len_err     <= len_err_nxt;
      timeout_err <= to_err_nxt;
    end
  end

  // Shadow buffer collects the packet; outputs only change on a CRC-good packet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      byte_cnt    <= '0;
      crc         <= '0;
      payload_len <= '0;
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= '0;
        obuf[i]   <= '0;
      end
    end else begin
      if (ld_len) begin
        len_q    <= rx.rx_data;
        byte_cnt <= '0;
        crc      <= '0;
        for (int i = 0; i < 16; i++) shadow[i] <= '0;
      end
      if (ld_data) begin
        shadow[byte_cnt[3:0]] <= rx.rx_data;
        crc                   <= next_crc8_d8(rx.rx_data, crc);
        byte_cnt              <= byte_cnt + 5'd1;
      end
      if (ld_out) begin
        payload_len <= len_q;
        for (int i = 0; i < 16; i++) obuf[i] <= shadow[i];
      end
    end
  end

  assign buf0  = obuf[0];
  assign buf1  = obuf[1];
  assign buf2  = obuf[2];
  assign buf3  = obuf[3];
  assign buf4  = obuf[4];
  assign buf5  = obuf[5];
  assign buf6  = obuf[6];
  assign buf7  = obuf[7];
  assign buf8  = obuf[8];
  assign buf9  = obuf[9];
  assign buf10 = obuf[10];
  assign buf11 = obuf[11];
  assign buf12 = obuf[12];
  assign buf13 = obuf[13];
  assign buf14 = obuf[14];
  assign buf15 = obuf[15];

endmodule

// File: tb/tb_s3g_rx.sv
// Self-checking bench for s3g_rx: expected packet outcomes are queued as bytes are sent
// and compared when the framer pulses packet_rdy / crc_err / len_err / timeout_err.
module tb_s3g_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s3g_rx_if rxif ();

  logic       packet_rdy, crc_err, len_err, timeout_err, busy;
  logic [7:0] payload_len;
  logic [7:0] b [16];

  s3g_rx #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rx(rxif),
    .packet_rdy(packet_rdy), .crc_err(crc_err), .len_err(len_err),
    .timeout_err(timeout_err), .busy(busy), .payload_len(payload_len),
    .buf0(b[0]), .buf1(b[1]), .buf2(b[2]), .buf3(b[3]),
    .buf4(b[4]), .buf5(b[5]), .buf6(b[6]), .buf7(b[7]),
    .buf8(b[8]), .buf9(b[9]), .buf10(b[10]), .buf11(b[11]),
    .buf12(b[12]), .buf13(b[13]), .buf14(b[14]), .buf15(b[15])
  );

  localparam int K_RDY = 0, K_CRC = 1, K_LEN = 2, K_TO = 3;

  typedef struct {
    int         kind;
    logic [7:0] len;
    logic [7:0] data [16];
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_len;
  logic [7:0] m_buf [16];
  int         n_chk = 0;
  int         n_pass = 0;

  // Bit-serial reference CRC8 (poly 0x07, seed 0x00)
  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic push_exp(input int kind);
    exp_t e;
    e.kind = kind;
    e.len  = m_len;
    for (int i = 0; i < 16; i++) e.data[i] = m_buf[i];
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] v);
    rxif.rx_valid = 1'b1;
    rxif.rx_data  = v;
    @(posedge clk);
    #1;
    rxif.rx_valid = 1'b0;
    rxif.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] pl [$], input bit corrupt);
    logic [7:0] c;
    c = 8'h00;
    foreach (pl[i]) c = crc_model(c, pl[i]);
    send(8'hD5);
    send(8'(pl.size()));
    foreach (pl[i]) send(pl[i]);
    if (corrupt) begin
      push_exp(K_CRC);
      send(c ^ 8'h01);
    end else begin
      m_len = 8'(pl.size());
      for (int i = 0; i < 16; i++) m_buf[i] = (i < pl.size()) ? pl[i] : 8'h00;
      push_exp(K_RDY);
      send(c);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      $display("FAIL %s pending_outcomes got %0d want 0", name, sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  // Outcome monitor: every pulse must match the oldest queued expectation
  int   mon_np;
  int   mon_kind;
  int   mon_bad;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_np = int'(packet_rdy) + int'(crc_err) + int'(len_err) + int'(timeout_err);
      if (mon_np != 0) begin
        n_chk++;
        if (mon_np != 1) $display("FAIL one_pulse got %0d pulses want 1", mon_np);
        else n_pass++;
        mon_kind = packet_rdy ? K_RDY : crc_err ? K_CRC : len_err ? K_LEN : K_TO;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_pulse got kind %0d want none", mon_kind);
        end else begin
          n_pass++;
          mon_e = sb.pop_front();
          n_chk++;
          if (mon_kind != mon_e.kind) $display("FAIL pulse_kind got %0d want %0d", mon_kind, mon_e.kind);
          else n_pass++;
          n_chk++;
          if (payload_len !== mon_e.len) $display("FAIL payload_len got %h want %h", payload_len, mon_e.len);
          else n_pass++;
          mon_bad = -1;
          for (int i = 15; i >= 0; i--) if (b[i] !== mon_e.data[i]) mon_bad = i;
          n_chk++;
          if (mon_bad >= 0)
            $display("FAIL buf%0d got %h want %h", mon_bad, b[mon_bad], mon_e.data[mon_bad]);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    rxif.rx_valid = 1'b0;
    rxif.rx_data  = 8'h00;
    m_len = 8'h00;
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++;
    if ({packet_rdy, crc_err, len_err, timeout_err} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {packet_rdy, crc_err, len_err, timeout_err});
    else n_pass++;
    n_chk++;
    if (payload_len !== 8'h00 || b[0] !== 8'h00 || b[15] !== 8'h00)
      $display("FAIL reset_outputs got len %h buf0 %h buf15 %h want 00", payload_len, b[0], b[15]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good();
    logic [7:0] pl [$];
    pl = '{8'h00};
    send_packet(pl, 1'b0);
    n_chk++;
    if (packet_rdy !== 1'b1) $display("FAIL good_rdy got %b want 1", packet_rdy); else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL good_busy got %b want 0", busy); else n_pass++;
    drain("good");
  endtask

  task automatic test_empty();
    logic [7:0] pl [$];
    send_packet(pl, 1'b0);
    n_chk++;
    if (packet_rdy !== 1'b1 || payload_len !== 8'h00)
      $display("FAIL empty_pkt got rdy %b len %h want 1 00", packet_rdy, payload_len);
    else n_pass++;
    drain("empty");
  endtask

  task automatic test_crc_err();
    logic [7:0] pl [$];
    pl = '{8'h5A};
    send_packet(pl, 1'b0);
    drain("crc_pre");
    pl = '{8'h00};
    send_packet(pl, 1'b1);
    n_chk++;
    if (crc_err !== 1'b1 || packet_rdy !== 1'b0)
      $display("FAIL crc_pulse got crc_err %b rdy %b want 1 0", crc_err, packet_rdy);
    else n_pass++;
    n_chk++;
    if (b[0] !== 8'h5A) $display("FAIL crc_hold_buf0 got %h want 5a", b[0]); else n_pass++;
    drain("crc_err");
  endtask

  task automatic test_noise_len();
    send(8'h12);
    send(8'h34);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL noise_busy got %b want 0", busy); else n_pass++;
    send(8'hD5);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL sof_busy got %b want 1", busy); else n_pass++;
    push_exp(K_LEN);
    send(8'h11);
    n_chk++;
    if (len_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL len_err got len_err %b busy %b want 1 0", len_err, busy);
    else n_pass++;
    drain("len_err");
  endtask

  task automatic test_full16();
    logic [7:0] pl [$];
    for (int i = 1; i <= 16; i++) pl.push_back(8'(i));
    send_packet(pl, 1'b0);
    n_chk++;
    if (b[15] !== 8'h10) $display("FAIL full16_buf15 got %h want 10", b[15]); else n_pass++;
    drain("full16");
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa [$];
    logic [7:0] pb [$];
    pa = '{8'hD5, 8'h33};
    pb = '{8'h77, 8'h88, 8'h99};
    send_packet(pa, 1'b0);
    send_packet(pb, 1'b0);
    n_chk++;
    if (payload_len !== 8'h03 || b[2] !== 8'h99)
      $display("FAIL b2b_second got len %h buf2 %h want 03 99", payload_len, b[2]);
    else n_pass++;
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    send(8'hD5);
    send(8'h05);
    send(8'hAA);
    rst = 1'b0;
    #2;
    n_chk++;
    if (busy !== 1'b0 || {packet_rdy, crc_err, len_err, timeout_err} !== 4'b0000)
      $display("FAIL midrst_ctrl got busy %b pulses %b want 0", busy,
               {packet_rdy, crc_err, len_err, timeout_err});
    else n_pass++;
    n_chk++;
    if (payload_len !== 8'h00 || b[0] !== 8'h00)
      $display("FAIL midrst_outputs got len %h buf0 %h want 00", payload_len, b[0]);
    else n_pass++;
    m_len = 8'h00;
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_good();
  endtask

`ifdef S3G_RX_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] pl [$];
    send(8'hD5);
    push_exp(K_TO);
    idle(7);
    n_chk++;
    if (timeout_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL to_early got to %b busy %b want 0 1", timeout_err, busy);
    else n_pass++;
    idle(1);
    n_chk++;
    if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_fire got to %b busy %b want 1 0", timeout_err, busy);
    else n_pass++;
    drain("timeout");
    send_packet(pl, 1'b0);
    drain("after_timeout");
    send(8'hD5);
    idle(7);
    send(8'h00);
    m_len = 8'h00;
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    push_exp(K_RDY);
    send(8'h00);
    drain("to_priority");
  endtask
`endif

  initial begin
    test_reset();
    test_good();
    test_empty();
    test_crc_err();
    test_noise_len();
    test_full16();
    test_back_to_back();
    test_reset_mid();
`ifdef S3G_RX_TIMEOUT_EN
    test_timeout();
`endif
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
